mem_dbus_access: RTL and testbench
==================================

// Module: mem_dbus_access
// PURPOSE
//  MEM-stage data-bus access controller. Consumes the EX/MEM pipeline register outputs (memory
//  enable, byte strobes, vaddr, wdata). Runs the request/address-ok/data-ok handshake to the data bus.
//  Stalls the pipeline while an access is outstanding. Returns aligned, sign/zero-extended load data
//  and address-error flags to the MEM/WB side.
// PARAMETERS
//  KSEG_MAP  1  1: kseg0/kseg1 vaddr (vaddr[31:30]==2'b10) maps to paddr = {3'b000, vaddr[28:0]};
//               0: paddr = vaddr
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset; synchronous, active-high
//  flush         in   1   pipeline flush (exception/eret), cancels the current access
//  m_en          in   1   memory access valid this cycle (from EX/MEM register)
//  m_wen         in   4   byte write strobes, already lane-shifted; 0 = load
//  m_size        in   2   0 = byte, 1 = half, 2 = word
//  m_sext        in   1   load sign-extend
//  m_vaddr       in   32  virtual address
//  m_wdata       in   32  store data, already lane-replicated
//  dbus_req      out  1   request valid
//  dbus_wr       out  1   1 = write
//  dbus_size     out  2   = m_size
//  dbus_addr     out  32  physical address
//  dbus_wstrb    out  4   = m_wen
//  dbus_wdata    out  32  = m_wdata
//  dbus_addr_ok  in   1   request accepted
//  dbus_data_ok  in   1   read data valid / write done
//  dbus_rdata    in   32  raw read word
//  rdata         out  32  aligned, extended load result
//  rvalid        out  1   one-cycle pulse: access done, rdata valid
//  excp_adel     out  1   misaligned load (combinational)
//  excp_ades     out  1   misaligned store (combinational)
//  stallreq      out  1   stall request to the pipeline controller
// BEHAVIOUR
//  - Reset: state=IDLE, dbus_req=0, rdata=0, rvalid=0, cancel=0. Bus address/data outputs are don't-care while req=0.
//  - misalign = (size==1 & vaddr[0]) | (size==2 & vaddr[1:0]!=0).
//    excp_adel = m_en & misalign & (m_wen==0); excp_ades = m_en & misalign & (m_wen!=0).
//  - start = m_en & ~misalign & ~flush in IDLE.
//  - FSM IDLE->REQ->WAIT->DONE->IDLE:
//    IDLE: on start go to REQ; latch addr/wr/size/strobes/wdata/vaddr[1:0]/sext.
//    REQ: dbus_req=1, bus fields from the latches, held stable until addr_ok.
//      addr_ok & data_ok in the same cycle -> DONE; addr_ok alone -> WAIT.
//    WAIT: on data_ok capture dbus_rdata, then go to DONE.
//    DONE: rvalid=1 for 1 cycle, then IDLE.
//  - Minimum latency: start cycle + REQ (with addr_ok & data_ok together) -> rvalid 2 cycles after start.
//  - stallreq = start | state==REQ | state==WAIT. It is low in DONE, so the pipeline advances exactly once per access.
//  - Load extract: byte lane vaddr[1:0]; half lane vaddr[1]. Extend per sext. Writes give rdata=0.
//  - Flush in REQ or WAIT: set cancel. A request is never withdrawn: REQ holds until addr_ok, WAIT until data_ok.
//    On completion go directly to IDLE with no rvalid and rdata unchanged. stallreq stays high until drained.
//  - Flush in DONE or IDLE: no effect on the FSM. Flush in IDLE suppresses start.
//  - rst in any state: immediate IDLE next edge; an outstanding bus response is ignored.
//  - The input is not re-sampled during an access; the EX/MEM register is held by stallreq.
// STRUCTURE
//  - Shared defines file: size codes (SZ_BYTE/HALF/WORD), FSM state encodings, ZeroWord.
//  - One natural sub-module: mem_load_align (combinational lane select + extend), reused by WB forwarding.
// TESTING
//  1. lw 0x80001000; addr_ok & data_ok same cycle as req, rdata 0x12345678
//     -> dbus_addr=0x00001000, rvalid 2 cycles after start, rdata=0x12345678.
//  2. lb vaddr ...03 sext=1, rdata 0x80FFFFFF -> 0xFFFFFF80; lbu same -> 0x00000080; lh ...02, 0x8001xxxx -> 0xFFFF8001.
//  3. lw vaddr 0x80000002 -> excp_adel=1, dbus_req never asserted, stallreq=0; sh ...01 -> excp_ades=1.
//  4. sw, addr_ok delayed 3 cycles, data_ok 2 later
//     -> req/addr/wdata/wstrb=4'hF stable throughout, stallreq high 6 cycles, rvalid once.
//  5. flush in WAIT; data_ok 4 cycles later -> no rvalid, stallreq high until data_ok, next lw issues normally.
//  6. rst asserted in WAIT -> state IDLE, req=0, rvalid=0 next cycle; stray data_ok afterwards ignored.

Source files
------------

// File: rtl/mem_dbus_access_pkg.sv
// rtl/mem_dbus_access_pkg.sv - shared size codes, FSM states and helpers for the MEM-stage data-bus access
package mem_dbus_access_pkg;

    localparam logic [1:0]  SZ_BYTE  = 2'd0;
    localparam logic [1:0]  SZ_HALF  = 2'd1;
    localparam logic [1:0]  SZ_WORD  = 2'd2;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects the addressed byte/half lane of a raw bus word and extends it
module mem_load_align
    import mem_dbus_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_sext & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_dbus_access.sv
// rtl/mem_dbus_access.sv - MEM-stage data-bus request/addr_ok/data_ok controller with pipeline stall
module mem_dbus_access
    import mem_dbus_access_pkg::*;
#(
    parameter logic KSEG_MAP = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_m_en,
    input  logic [3:0]  i_m_wen,
    input  logic [1:0]  i_m_size,
    input  logic        i_m_sext,
    input  logic [31:0] i_m_vaddr,
    input  logic [31:0] i_m_wdata,
    output logic        o_dbus_req,
    output logic        o_dbus_wr,
    output logic [1:0]  o_dbus_size,
    output logic [31:0] o_dbus_addr,
    output logic [3:0]  o_dbus_wstrb,
    output logic [31:0] o_dbus_wdata,
    input  logic        i_dbus_addr_ok,
    input  logic        i_dbus_data_ok,
    input  logic [31:0] i_dbus_rdata,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_excp_adel,
    output logic        o_excp_ades,
    output logic        o_stallreq
);

    mem_state_e  r_state;
    logic        r_req, r_wr, r_sext, r_cancel, r_rvalid;
    logic [1:0]  r_size, r_lane;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr, r_wdata, r_rdata;

    logic        w_misalign, w_start, w_complete;
    logic [31:0] w_paddr, w_load_data;

    assign w_misalign  = is_misaligned(i_m_size, i_m_vaddr[1:0]);
    assign o_excp_adel = i_m_en & w_misalign & (i_m_wen == 4'b0000);
    assign o_excp_ades = i_m_en & w_misalign & (i_m_wen != 4'b0000);
    assign w_start     = (r_state == ST_IDLE) & i_m_en & ~w_misalign & ~i_flush;
    assign w_paddr     = (KSEG_MAP && (i_m_vaddr[31:30] == 2'b10)) ?
                         {3'b000, i_m_vaddr[28:0]} : i_m_vaddr;
    assign w_complete  = ((r_state == ST_REQ) & i_dbus_addr_ok & i_dbus_data_ok) |
                         ((r_state == ST_WAIT) & i_dbus_data_ok);

    mem_load_align u_align (
        .i_word (i_dbus_rdata),
        .i_lane (r_lane),
        .i_size (r_size),
        .i_sext (r_sext),
        .o_data (w_load_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_req    <= 1'b0;
            r_wr     <= 1'b0;
            r_sext   <= 1'b0;
            r_cancel <= 1'b0;
            r_rvalid <= 1'b0;
            r_size   <= SZ_BYTE;
            r_lane   <= 2'b00;
            r_wstrb  <= 4'b0000;
            r_addr   <= ZeroWord;
            r_wdata  <= ZeroWord;
            r_rdata  <= ZeroWord;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state  <= ST_REQ;
                        r_req    <= 1'b1;
                        r_wr     <= (i_m_wen != 4'b0000);
                        r_sext   <= i_m_sext;
                        r_size   <= i_m_size;
                        r_lane   <= i_m_vaddr[1:0];
                        r_wstrb  <= i_m_wen;
                        r_addr   <= w_paddr;
                        r_wdata  <= i_m_wdata;
                        r_cancel <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (i_flush) r_cancel <= 1'b1;
                    if (i_dbus_addr_ok) begin
                        r_req   <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_flush) r_cancel <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
            // A flushed access still drains the bus but retires silently
            if (w_complete) begin
                if (r_cancel | i_flush) begin
                    r_state  <= ST_IDLE;
                    r_cancel <= 1'b0;
                end else begin
                    r_state  <= ST_DONE;
                    r_rvalid <= 1'b1;
                    r_rdata  <= r_wr ? ZeroWord : w_load_data;
                end
            end
        end
    end

    assign o_dbus_req   = r_req;
    assign o_dbus_wr    = r_wr;
    assign o_dbus_size  = r_size;
    assign o_dbus_addr  = r_addr;
    assign o_dbus_wstrb = r_wstrb;
    assign o_dbus_wdata = r_wdata;
    assign o_rdata      = r_rdata;
    assign o_rvalid     = r_rvalid;
    assign o_stallreq   = w_start | (r_state == ST_REQ) | (r_state == ST_WAIT);

endmodule

// File: tb/tb_mem_dbus_access.sv
// tb/tb_mem_dbus_access.sv - directed self-checking bench for mem_dbus_access
module tb_mem_dbus_access;

    logic        clk = 1'b0;
    logic        rst, flush, m_en, m_sext;
    logic [3:0]  m_wen;
    logic [1:0]  m_size;
    logic [31:0] m_vaddr, m_wdata;
    logic        dbus_req, dbus_wr;
    logic [1:0]  dbus_size;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        addr_ok, data_ok;
    logic [31:0] dbus_rdata, rdata;
    logic        rvalid, adel, ades, stallreq;

    int errors = 0;
    int checks = 0;
    int stalls, rvs;

    always #5 clk = ~clk;

    mem_dbus_access #(.KSEG_MAP(1'b1)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_flush        (flush),
        .i_m_en         (m_en),
        .i_m_wen        (m_wen),
        .i_m_size       (m_size),
        .i_m_sext       (m_sext),
        .i_m_vaddr      (m_vaddr),
        .i_m_wdata      (m_wdata),
        .o_dbus_req     (dbus_req),
        .o_dbus_wr      (dbus_wr),
        .o_dbus_size    (dbus_size),
        .o_dbus_addr    (dbus_addr),
        .o_dbus_wstrb   (dbus_wstrb),
        .o_dbus_wdata   (dbus_wdata),
        .i_dbus_addr_ok (addr_ok),
        .i_dbus_data_ok (data_ok),
        .i_dbus_rdata   (dbus_rdata),
        .o_rdata        (rdata),
        .o_rvalid       (rvalid),
        .o_excp_adel    (adel),
        .o_excp_ades    (ades),
        .o_stallreq     (stallreq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_acc(input logic [31:0] va, input logic [3:0] wen, input logic [1:0] sz,
                           input logic sx, input logic [31:0] wd);
        m_en = 1'b1; m_vaddr = va; m_wen = wen; m_size = sz; m_sext = sx; m_wdata = wd;
    endtask

    // Zero-wait access: addr_ok and data_ok together in the REQ cycle
    task automatic fast_access(input string tag, input logic [31:0] va, input logic [3:0] wen,
                               input logic [1:0] sz, input logic sx, input logic [31:0] raw,
                               input logic [31:0] exp_pa, input logic [31:0] exp_rd);
        set_acc(va, wen, sz, sx, 32'h0);
        #1;
        chk({tag, ".start_stall"}, {31'b0, stallreq}, 32'd1);
        chk({tag, ".start_req"}, {31'b0, dbus_req}, 32'd0);
        tick();
        chk({tag, ".req"}, {31'b0, dbus_req}, 32'd1);
        chk({tag, ".addr"}, dbus_addr, exp_pa);
        addr_ok = 1'b1; data_ok = 1'b1; dbus_rdata = raw;
        tick();
        addr_ok = 1'b0; data_ok = 1'b0; dbus_rdata = 32'h0; m_en = 1'b0;
        #1;
        chk({tag, ".rvalid"}, {31'b0, rvalid}, 32'd1);
        chk({tag, ".rdata"}, rdata, exp_rd);
        chk({tag, ".done_stall"}, {31'b0, stallreq}, 32'd0);
        tick();
        chk({tag, ".rvalid_drop"}, {31'b0, rvalid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; m_en = 1'b0; m_wen = 4'h0; m_size = 2'd0; m_sext = 1'b0;
        m_vaddr = 32'h0; m_wdata = 32'h0; addr_ok = 1'b0; data_ok = 1'b0; dbus_rdata = 32'h0;
        tick(); tick();
        chk("rst.req", {31'b0, dbus_req}, 32'd0);
        chk("rst.rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.stall", {31'b0, stallreq}, 32'd0);
        rst = 1'b0;
        tick();

        fast_access("lw", 32'h8000_1000, 4'h0, 2'd2, 1'b0, 32'h1234_5678, 32'h0000_1000, 32'h1234_5678);

        // Misaligned accesses raise the exception and never reach the bus
        set_acc(32'h8000_0002, 4'h0, 2'd2, 1'b0, 32'h0);
        #1;
        chk("lw_mis.adel", {31'b0, adel}, 32'd1);
        chk("lw_mis.ades", {31'b0, ades}, 32'd0);
        chk("lw_mis.stall", {31'b0, stallreq}, 32'd0);
        tick();
        chk("lw_mis.req", {31'b0, dbus_req}, 32'd0);
        set_acc(32'h8000_0001, 4'b0110, 2'd1, 1'b0, 32'h5555_5555);
        #1;
        chk("sh_mis.ades", {31'b0, ades}, 32'd1);
        chk("sh_mis.adel", {31'b0, adel}, 32'd0);
        chk("sh_mis.stall", {31'b0, stallreq}, 32'd0);
        tick();
        chk("sh_mis.req", {31'b0, dbus_req}, 32'd0);
        m_en = 1'b0;
        tick();

        // Store with addr_ok on the third REQ cycle and data_ok two cycles later
        stalls = 0; rvs = 0;
        set_acc(32'h8000_0010, 4'hF, 2'd2, 1'b0, 32'hDEAD_BEEF);
        for (int c = 0; c < 8; c++) begin
            addr_ok = (c == 3);
            data_ok = (c == 5);
            m_en    = (c <= 6);
            #1;
            if (stallreq) stalls++;
            if (rvalid) rvs++;
            chk("sw.rvalid", {31'b0, rvalid}, {31'b0, (c == 6)});
            if (c >= 1 && c <= 3) begin
                chk("sw.req", {31'b0, dbus_req}, 32'd1);
                chk("sw.addr", dbus_addr, 32'h0000_0010);
                chk("sw.wdata", dbus_wdata, 32'hDEAD_BEEF);
                chk("sw.wstrb", {28'b0, dbus_wstrb}, 32'hF);
                chk("sw.wr", {31'b0, dbus_wr}, 32'd1);
            end
            if (c == 4) chk("sw.req_wait", {31'b0, dbus_req}, 32'd0);
            if (c == 6) chk("sw.rdata", rdata, 32'h0);
            tick();
        end
        addr_ok = 1'b0; data_ok = 1'b0;
        chk("sw.stall_cycles", stalls, 32'd6);
        chk("sw.rvalid_count", rvs, 32'd1);

        fast_access("lb", 32'h8000_0003, 4'h0, 2'd0, 1'b1, 32'h80FF_FFFF, 32'h0000_0003, 32'hFFFF_FF80);
        fast_access("lbu", 32'hA000_0003, 4'h0, 2'd0, 1'b0, 32'h80FF_FFFF, 32'h0000_0003, 32'h0000_0080);
        fast_access("lh", 32'h0000_0102, 4'h0, 2'd1, 1'b1, 32'h8001_1234, 32'h0000_0102, 32'hFFFF_8001);

        // Flush while waiting for data: drains silently, rdata keeps the previous load
        set_acc(32'h8000_0020, 4'h0, 2'd2, 1'b0, 32'h0);
        for (int c = 0; c < 8; c++) begin
            addr_ok    = (c == 1);
            flush      = (c == 2);
            if (c == 2) m_en = 1'b0;
            data_ok    = (c == 6);
            dbus_rdata = (c == 6) ? 32'hAAAA_AAAA : 32'h0;
            #1;
            chk("flush.stall", {31'b0, stallreq}, {31'b0, (c <= 6)});
            chk("flush.rvalid", {31'b0, rvalid}, 32'd0);
            tick();
        end
        addr_ok = 1'b0; data_ok = 1'b0; flush = 1'b0;
        chk("flush.rdata_kept", rdata, 32'hFFFF_8001);

        // Flush in IDLE blocks the start
        set_acc(32'h8000_0030, 4'h0, 2'd2, 1'b0, 32'h0);
        flush = 1'b1;
        #1;
        chk("idle_flush.stall", {31'b0, stallreq}, 32'd0);
        tick();
        flush = 1'b0; m_en = 1'b0;
        chk("idle_flush.req", {31'b0, dbus_req}, 32'd0);
        tick();

        fast_access("lw_after_flush", 32'h8000_0040, 4'h0, 2'd2, 1'b0, 32'h0BAD_F00D, 32'h0000_0040, 32'h0BAD_F00D);

        // Reset in WAIT abandons the access; a late data_ok is ignored
        set_acc(32'h8000_0050, 4'h0, 2'd2, 1'b0, 32'h0);
        tick();
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0; rst = 1'b1; m_en = 1'b0;
        #1;
        chk("rst_wait.stall_before", {31'b0, stallreq}, 32'd1);
        tick();
        rst = 1'b0; data_ok = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_wait.req", {31'b0, dbus_req}, 32'd0);
        chk("rst_wait.rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_wait.stall", {31'b0, stallreq}, 32'd0);
        tick();
        data_ok = 1'b0;
        #1;
        chk("rst_wait.stray_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_wait.rdata", rdata, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
